// File: rtl/cell_sdpram_sclk.sv
// Single-clock simple dual-port RAM: one synchronous write port, one registered read port,
// with optional same-address write-to-read bypass ahead of the output register.
module cell_sdpram_sclk #(
  parameter int unsigned AW            = 8,
  parameter int unsigned DW            = 32,
  parameter int unsigned ENABLE_BYPASS = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] raddr,
  input  logic          re,
  output logic [DW-1:0] dout,
  input  logic [AW-1:0] waddr,
  input  logic          we,
  input  logic [DW-1:0] din
);

  localparam int unsigned Depth = 1 << AW;

  logic [DW-1:0] mem_q [Depth];
  logic [DW-1:0] dout_d;
  logic [DW-1:0] dout_q;
  logic          collide;

  // Array is not reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (we && rst_n) begin
      mem_q[waddr] <= din;
    end
  end

  always_comb begin
    collide = we && (raddr == waddr);
    dout_d  = mem_q[raddr];
    if ((ENABLE_BYPASS != 0) && collide) begin
      dout_d = din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
    end else if (re) begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_cell_sdpram_sclk.sv
// Directed bench for cell_sdpram_sclk: one write-first and one read-first instance
// driven by identical stimulus, each checked against hand-computed values.
module tb_cell_sdpram_sclk;

  localparam int unsigned AW = 3;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [AW-1:0] raddr = '0;
  logic          re = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic          we = 1'b0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout_byp;
  logic [DW-1:0] dout_nob;

  int tests = 0;
  int fails = 0;

  cell_sdpram_sclk #(.AW(AW), .DW(DW), .ENABLE_BYPASS(1)) u_byp (
    .clk  (clk),
    .rst_n(rst_n),
    .raddr(raddr),
    .re   (re),
    .dout (dout_byp),
    .waddr(waddr),
    .we   (we),
    .din  (din)
  );

  cell_sdpram_sclk #(.AW(AW), .DW(DW), .ENABLE_BYPASS(0)) u_nob (
    .clk  (clk),
    .rst_n(rst_n),
    .raddr(raddr),
    .re   (re),
    .dout (dout_nob),
    .waddr(waddr),
    .we   (we),
    .din  (din)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_both(input string tag, input logic [DW-1:0] exp);
    check({tag, "_byp"}, dout_byp, exp);
    check({tag, "_nob"}, dout_nob, exp);
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    we    = 1'b1;
    waddr = a;
    din   = d;
    step();
    we    = 1'b0;
  endtask

  task automatic read(input logic [AW-1:0] a);
    re    = 1'b1;
    raddr = a;
    step();
    re    = 1'b0;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 check_both("reset_async", 32'h0);

    // Clock edge with re=1 while in reset must not load.
    re    = 1'b1;
    raddr = 3'd0;
    step();
    check_both("reset_hold", 32'h0);
    re    = 1'b0;
    #2 rst_n = 1'b1;

    write(3'd5, 32'hDEADBEEF);
    write(3'd2, 32'h11111111);
    write(3'd1, 32'hA5A5A5A5);
    write(3'd3, 32'h00000033);
    write(3'd6, 32'h66666666);

    read(3'd5);
    check_both("write_read", 32'hDEADBEEF);

    // Same-address collision.
    we    = 1'b1;
    waddr = 3'd2;
    din   = 32'h22222222;
    re    = 1'b1;
    raddr = 3'd2;
    step();
    we    = 1'b0;
    re    = 1'b0;
    check("collide_byp", dout_byp, 32'h22222222);
    check("collide_nob", dout_nob, 32'h11111111);
    read(3'd2);
    check_both("collide_reread", 32'h22222222);

    // Output holds while re=0, even across writes to the address last read.
    read(3'd1);
    check_both("hold_load", 32'hA5A5A5A5);
    for (int i = 0; i < 4; i++) begin
      we    = 1'b1;
      waddr = 3'd1;
      din   = 32'h0;
      raddr = AW'(i + 4);
      step();
      check_both("hold", 32'hA5A5A5A5);
    end
    we = 1'b0;
    read(3'd1);
    check_both("hold_newdata", 32'h0);

    // Independent ports, different addresses.
    we    = 1'b1;
    waddr = 3'd4;
    din   = 32'h00000077;
    re    = 1'b1;
    raddr = 3'd3;
    step();
    we    = 1'b0;
    check_both("indep_read", 32'h00000033);
    raddr = 3'd4;
    step();
    check_both("indep_next", 32'h00000077);

    // Back-to-back reads.
    raddr = 3'd5;
    step();
    check_both("b2b_0", 32'hDEADBEEF);
    raddr = 3'd2;
    step();
    check_both("b2b_1", 32'h22222222);
    raddr = 3'd6;
    step();
    check_both("b2b_2", 32'h66666666);
    re = 1'b0;

    // Async reset mid-stream; writes ignored during reset; array retained.
    read(3'd5);
    check_both("pre_reset", 32'hDEADBEEF);
    #2 rst_n = 1'b0;
    #1 check_both("reset_mid", 32'h0);
    we    = 1'b1;
    waddr = 3'd6;
    din   = 32'h0BAD0BAD;
    re    = 1'b1;
    raddr = 3'd6;
    step();
    check_both("reset_mid_edge", 32'h0);
    we = 1'b0;
    re = 1'b0;
    #2 rst_n = 1'b1;
    read(3'd5);
    check_both("post_reset_retain", 32'hDEADBEEF);
    read(3'd6);
    check_both("post_reset_nowrite", 32'h66666666);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
